// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: sequences one structuralFullAdder LSB first, carry fed back via a register.
// Optional macro SERIAL_ADDER_OVERFLOW_EN adds a signed-overflow output held alongside sum.

module structuralFullAdder (
    input  logic a,
    input  logic b,
    input  logic carryin,
    output logic sum,
    output logic carryout
);
    logic axb;

    assign axb      = a ^ b;
    assign sum      = axb ^ carryin;
    assign carryout = (a & b) | (axb & carryin);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, next_state;
    logic [WIDTH-1:0]   a_sh, b_sh, sum_sh, sum_next;
    logic               c_reg;
    logic [CNT_W-1:0]   cnt;
    logic               load, last;
    logic               fa_sum, fa_cout;

    structuralFullAdder u_fa (
        .a        (a_sh[0]),
        .b        (b_sh[0]),
        .carryin  (c_reg),
        .sum      (fa_sum),
        .carryout (fa_cout)
    );

    assign last     = (cnt == CNT_W'(WIDTH - 1));
    assign sum_next = {fa_sum, sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) next_state = DONE;
            end
            DONE: begin
                done = 1'b1;
                // A start on the done cycle reloads directly, skipping IDLE.
                if (start) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            c_reg    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            carryout <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            c_reg <= carryin;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            sum_sh <= sum_next;
            c_reg  <= fa_cout;
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            cnt    <= cnt + 1'b1;
            if (last) begin
                sum      <= sum_next;
                carryout <= fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                // c_reg is the carry into the MSB during the final bit.
                overflow <= c_reg ^ fa_cout;
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed WIDTH=8 cases plus an exhaustive WIDTH=4 sweep.
// Expected results are queued at stimulus time and compared on every done pulse.

module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic       ovf8, ovf4;
`endif

    int vectors = 0;
    int errors  = 0;

    logic [9:0] sb8[$];   // {overflow, carryout, sum}
    logic [4:0] sb4[$];   // {carryout, sum}

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .carryin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .carryout(cout8)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , .overflow(ovf8)
`endif
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .carryin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .carryout(cout4)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , .overflow(ovf4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] s;
        logic       v;
        s = {1'b0, x} + {1'b0, y} + {8'd0, c};
        v = (x[7] == y[7]) && (s[7] != x[7]);
        return {v, s};
    endfunction

    always @(negedge clk) begin
        if (done8) begin
            if (sb8.size() == 0) begin
                check("unexpected_done8", 32'(done8), 32'd0);
            end else begin
                logic [9:0] e;
                e = sb8.pop_front();
                check("sum8", 32'(sum8), 32'(e[7:0]));
                check("cout8", 32'(cout8), 32'(e[8]));
`ifdef SERIAL_ADDER_OVERFLOW_EN
                check("ovf8", 32'(ovf8), 32'(e[9]));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (done4) begin
            if (sb4.size() == 0) begin
                check("unexpected_done4", 32'(done4), 32'd0);
            end else begin
                logic [4:0] e;
                e = sb4.pop_front();
                check("sum4", 32'({cout4, sum4}), 32'(e));
            end
        end
    end

    task automatic drive8(input logic [7:0] x, input logic [7:0] y, input logic c);
        @(negedge clk);
        a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
        sb8.push_back(model8(x, y, c));
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    task automatic drain8();
        int n = 0;
        while (sb8.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain8", 32'(sb8.size()), 32'd0);
    endtask

    // Counts cycles from the accepting edge until done; returns the busy-cycle count too.
    task automatic measure8(output int k, output int nbusy, input logic [7:0] hold_exp);
        nbusy = 0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 4) check("sum_held_in_shift", 32'(sum8), 32'(hold_exp));
            if (busy8) nbusy++;
            if (done8) break;
        end
    endtask

    initial begin
        int k, nb, n;

        // Reset state
        #1;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Zero add with latency and busy-length check
        drive8(8'h00, 8'h00, 1'b0);
        measure8(k, nb, 8'h00);
        check("latency_done", 32'(k), 32'd9);
        check("busy_cycles", 32'(nb), 32'd8);
        drain8();

        // Carry / overflow corners
        drive8(8'hFF, 8'h01, 1'b0); drain8();
        drive8(8'h7F, 8'h01, 1'b0); drain8();
        drive8(8'hFF, 8'hFF, 1'b1); drain8();
        drive8(8'hA5, 8'h5A, 1'b1); drain8();
        drive8(8'h80, 8'h80, 1'b0); drain8();
        drive8(8'hA5, 8'h5A, 1'b0); drain8();

        // Reset mid-add aborts without a done pulse
        drive8(8'h11, 8'h22, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb8.delete();
        sb4.delete();
        #1;
        check("midrst_busy", 32'(busy8), 32'd0);
        check("midrst_done", 32'(done8), 32'd0);
        check("midrst_sum", 32'(sum8), 32'd0);
        check("midrst_cout", 32'(cout8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (14) begin
            @(negedge clk);
            if (done8) n++;
        end
        check("no_done_after_rst", 32'(n), 32'd0);
        check("idle_after_rst", 32'(busy8), 32'd0);

        // start held through SHIFT with changing operands is ignored
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        sb8.push_back(model8(8'h12, 8'h34, 1'b0));
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        end
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_seen_first", 32'(done8), 32'd1);

        // Back-to-back start on the done cycle
        a8 = 8'hC3; b8 = 8'h3C; cin8 = 1'b1; start8 = 1'b1;
        sb8.push_back(model8(8'hC3, 8'h3C, 1'b1));
        @(posedge clk);
        #1 start8 = 1'b0;
        measure8(k, nb, 8'h46);
        check("b2b_latency", 32'(k), 32'd9);
        drain8();

        // Exhaustive WIDTH=4 sweep
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c); start4 = 1'b1;
                    sb4.push_back(5'(x + y + c));
                    @(posedge clk);
                    #1 start4 = 1'b0;
                    n = 0;
                    while (sb4.size() != 0 && n < 12) begin
                        @(negedge clk);
                        n++;
                    end
                    check("drain4", 32'(sb4.size()), 32'd0);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
